// File: rtl/multdiv_iter_pkg.sv
// multdiv_iter shared types and constants.
// State encoding, iteration count and overflow helper.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        DONE
    } state_t;

    localparam int          ITER_COUNT = 32;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

    // Signed 32-bit overflow: bits [63:31] of the product disagree.
    function automatic logic mul_ovf(input logic [63:0] p);
        return !((&p[63:31]) || !(|p[63:31]));
    endfunction

endpackage

// File: rtl/multdiv_iter_if.sv
// multdiv_iter request/response bundle.
// master drives operands and start pulses; slave is the unit.
interface multdiv_iter_if #(
    parameter int WIDTH = 32
);

    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output data_operandA,
        output data_operandB,
        output ctrl_MULT,
        output ctrl_DIV,
        input  data_result,
        input  data_exception,
        input  data_resultRDY,
        input  busy
    );

    modport slave (
        input  data_operandA,
        input  data_operandB,
        input  ctrl_MULT,
        input  ctrl_DIV,
        output data_result,
        output data_exception,
        output data_resultRDY,
        output busy
    );

endinterface

// File: rtl/multdiv_iter_div.sv
// One restoring-division iteration.
// Shift rem:quo left, trial-subtract divisor, keep or restore.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH:0]   rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] quo_sh;
    logic [WIDTH:0]   diff;

    // Trial subtract; a set top bit means the divisor did not fit.
    always_comb begin
        rem_sh  = {rem[WIDTH-1:0], quo[WIDTH-1]};
        quo_sh  = {quo[WIDTH-2:0], 1'b0};
        diff    = rem_sh - {1'b0, dvs};
        rem_nxt = rem_sh;
        quo_nxt = quo_sh;
        if (!diff[WIDTH]) begin
            rem_nxt = diff;
            quo_nxt = quo_sh | {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring).
// 33-cycle latency; divide-by-zero answers after one cycle.
module multdiv_iter
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic         clock,
    input logic         reset_n,
    multdiv_iter_if.slave bus
);

    state_t state, state_n;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] hi, lo;
    logic             q1;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo, dvs;
    logic             neg, dz, ovf_d;
    logic [WIDTH-1:0] res_q;
    logic             exc_q;

    logic start_m, start_d, start;
    logic running, last, fin_c;
    logic ld_m, ld_d, step, fin;

    logic [WIDTH:0]   ax, hx, sum;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] a_abs, b_abs;

    assign start_m = bus.ctrl_MULT & ~bus.ctrl_DIV;
    assign start_d = bus.ctrl_DIV & ~bus.ctrl_MULT;
    assign start   = start_m | start_d;
    assign running = (state == MULT) || (state == DIV);
    assign last    = (cnt == CNT_W'(ITER_COUNT));
    assign fin_c   = running && (last || (state == DIV && dz));

    assign a_abs = bus.data_operandA[WIDTH-1] ? -bus.data_operandA
                                              : bus.data_operandA;
    assign b_abs = bus.data_operandB[WIDTH-1] ? -bus.data_operandB
                                              : bus.data_operandB;

    assign bus.data_result    = res_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = (state == DONE);
    assign bus.busy           = running;

    div_restore_step #(.WIDTH(WIDTH)) u_div (
        .rem     (rem),
        .quo     (quo),
        .dvs     (dvs),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    // Booth add/subtract on the sign-extended high half.
    always_comb begin
        ax  = {a_q[WIDTH-1], a_q};
        hx  = {hi[WIDTH-1], hi};
        sum = hx;
        case ({lo[0], q1})
            2'b01:   sum = hx + ax;
            2'b10:   sum = hx - ax;
            default: sum = hx;
        endcase
    end

    // Next state and datapath controls; a legal start always wins.
    always_comb begin
        state_n = state;
        ld_m    = 1'b0;
        ld_d    = 1'b0;
        step    = 1'b0;
        fin     = 1'b0;
        unique case (1'b1)
            start_m: begin
                state_n = MULT;
                ld_m    = 1'b1;
            end
            start_d: begin
                state_n = DIV;
                ld_d    = 1'b1;
            end
            !start && state == DONE: begin
                state_n = IDLE;
            end
            !start && fin_c: begin
                state_n = DONE;
                fin     = 1'b1;
            end
            !start && running && !fin_c: begin
                step = 1'b1;
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Operand capture and one Booth or restoring step per cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            a_q   <= '0;
            hi    <= '0;
            lo    <= '0;
            q1    <= 1'b0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            neg   <= 1'b0;
            dz    <= 1'b0;
            ovf_d <= 1'b0;
        end else if (ld_m) begin
            cnt <= '0;
            a_q <= bus.data_operandA;
            hi  <= '0;
            lo  <= bus.data_operandB;
            q1  <= 1'b0;
        end else if (ld_d) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= a_abs;
            dvs   <= b_abs;
            neg   <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            dz    <= (bus.data_operandB == '0);
            ovf_d <= (bus.data_operandA == INT_MIN) &&
                     (bus.data_operandB == '1);
        end else if (step) begin
            cnt <= cnt + 1'b1;
            if (state == MULT) begin
                hi <= sum[WIDTH:1];
                lo <= {sum[0], lo[WIDTH-1:1]};
                q1 <= lo[0];
            end else begin
                rem <= rem_nxt;
                quo <= quo_nxt;
            end
        end
    end

    // Result and flag, updated only on entry to DONE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            res_q <= '0;
            exc_q <= 1'b0;
        end else if (fin) begin
            if (state == MULT) begin
                res_q <= lo;
                exc_q <= mul_ovf({hi, lo});
            end else if (dz) begin
                res_q <= '0;
                exc_q <= 1'b1;
            end else begin
                res_q <= neg ? -quo : quo;
                exc_q <= ovf_d;
            end
        end
    end

endmodule
